// File: rtl/uart_mem_bridge_pkg.sv
// Shared definitions for the UART memory bridge: command codes, response
// codes, main and transmit sequencer state encodings.
package uart_mem_bridge_pkg;

   localparam logic [7:0] CMD_W = 8'h57;   // 'W' word write
   localparam logic [7:0] CMD_R = 8'h52;   // 'R' word read
   localparam logic [7:0] CMD_H = 8'h48;   // 'H' hold CPU
   localparam logic [7:0] CMD_G = 8'h47;   // 'G' release CPU

   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

   // Number of response bytes for single-byte replies and for read data
   localparam logic [2:0] RESP_ONE  = 3'd1;
   localparam logic [2:0] RESP_WORD = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_WRITE,
      ST_READ,
      ST_READ_WAIT,
      ST_SEND
   } state_t;

   typedef enum logic [1:0] {
      TXS_IDLE,
      TXS_SEND,
      TXS_GAP
   } tx_state_t;

endpackage

// File: rtl/uart_mem_bridge_tx_seq.sv
// Response transmitter sequencer: holds up to four response bytes and feeds
// them LSB first to the UART transmitter, waiting for it to go idle and
// leaving a short blind window after each launch while its busy flag rises.
module uart_mem_bridge_tx_seq
   import uart_mem_bridge_pkg::*;
#(
   parameter int TX_GAP = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_start,
   input  logic [31:0] i_data,
   input  logic [2:0]  i_count,
   input  logic        i_tx_busy,
   output logic        o_busy,
   output logic        o_tx_valid,
   output logic [7:0]  o_tx_byte
);

   localparam logic [7:0] GAP_LAST = 8'(TX_GAP - 1);

   tx_state_t   r_state;
   tx_state_t   w_state_nxt;
   logic [31:0] r_shift;
   logic [2:0]  r_count;
   logic [7:0]  r_gap;
   logic        r_tx_valid;
   logic [7:0]  r_tx_byte;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= TXS_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic: launch when transmitter idle, then sit out the gap
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         TXS_IDLE: if (i_start)    w_state_nxt = TXS_SEND;
         TXS_SEND: if (!i_tx_busy) w_state_nxt = TXS_GAP;
         TXS_GAP: begin
            if (r_gap == GAP_LAST) w_state_nxt = (r_count != 3'd0) ? TXS_SEND : TXS_IDLE;
         end
         default: w_state_nxt = TXS_IDLE;
      endcase
   end

   // Response shift register, byte counter, gap counter and tx outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift    <= '0;
         r_count    <= '0;
         r_gap      <= '0;
         r_tx_valid <= 1'b0;
         r_tx_byte  <= '0;
      end else begin
         r_tx_valid <= 1'b0;
         case (r_state)
            TXS_IDLE: begin
               if (i_start) begin
                  r_shift <= i_data;
                  r_count <= i_count;
               end
            end
            TXS_SEND: begin
               if (!i_tx_busy) begin
                  r_tx_valid <= 1'b1;
                  r_tx_byte  <= r_shift[7:0];
                  r_shift    <= {8'h00, r_shift[31:8]};
                  r_count    <= r_count - 3'd1;
                  r_gap      <= '0;
               end
            end
            TXS_GAP: r_gap <= r_gap + 8'd1;
            default: ;
         endcase
      end
   end

   assign o_busy     = (r_state != TXS_IDLE);
   assign o_tx_valid = r_tx_valid;
   assign o_tx_byte  = r_tx_byte;

endmodule

// File: rtl/uart_mem_bridge.sv
// UART-driven memory bus initiator. Decodes W/R/H/G command frames from the
// receive byte stream, performs single word accesses on the CPU-style memory
// bus and returns ACK/NAK or read data through the transmit sequencer.
module uart_mem_bridge
   import uart_mem_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 2_700_000,
   parameter int TX_GAP         = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte,
   output logic        tx_valid,
   output logic [7:0]  tx_byte,
   input  logic        tx_busy,
   output logic [31:0] mem_addr,
   output logic        mem_rstrb,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic [31:0] mem_rdata,
   output logic        cpu_hold
);

   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_is_write;
   logic [1:0]  r_byte_cnt;
   logic [23:0] r_addr_sh;
   logic [31:0] r_mem_addr;
   logic [31:0] r_wdata;
   logic        r_hold;
   logic [31:0] r_tmo;

   logic        w_in_frame;
   logic        w_tmo_hit;
   logic        w_start;
   logic [31:0] w_start_data;
   logic [2:0]  w_start_cnt;
   logic        w_seq_busy;

   // A byte arriving on the expiry cycle wins over the timeout
   assign w_in_frame = (r_state == ST_ADDR) || (r_state == ST_DATA);
   assign w_tmo_hit  = w_in_frame && !rx_valid && (r_tmo >= TMO_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Command decode, frame sequencing and response launch
   always_comb begin
      w_state_nxt  = r_state;
      w_start      = 1'b0;
      w_start_data = '0;
      w_start_cnt  = '0;
      case (r_state)
         ST_IDLE: begin
            if (rx_valid) begin
               if (rx_byte == CMD_W || rx_byte == CMD_R) begin
                  w_state_nxt = ST_ADDR;
               end else begin
                  w_start      = 1'b1;
                  w_start_cnt  = RESP_ONE;
                  w_start_data = (rx_byte == CMD_H || rx_byte == CMD_G) ? {24'h0, ACK} : {24'h0, NAK};
                  w_state_nxt  = ST_SEND;
               end
            end
         end
         ST_ADDR: begin
            if (rx_valid) begin
               if (r_byte_cnt == 2'd3) w_state_nxt = r_is_write ? ST_DATA : ST_READ;
            end else if (w_tmo_hit) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (rx_valid) begin
               if (r_byte_cnt == 2'd3) w_state_nxt = ST_WRITE;
            end else if (w_tmo_hit) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WRITE: begin
            w_start      = 1'b1;
            w_start_cnt  = RESP_ONE;
            w_start_data = {24'h0, ACK};
            w_state_nxt  = ST_SEND;
         end
         ST_READ: w_state_nxt = ST_READ_WAIT;
         ST_READ_WAIT: begin
            w_start      = 1'b1;
            w_start_cnt  = RESP_WORD;
            w_start_data = mem_rdata;
            w_state_nxt  = ST_SEND;
         end
         ST_SEND: if (!w_seq_busy) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Receive shift registers, byte counter, hold flag and inter-byte timeout
   always_ff @(posedge clk) begin
      if (reset) begin
         r_is_write <= 1'b0;
         r_byte_cnt <= '0;
         r_addr_sh  <= '0;
         r_mem_addr <= '0;
         r_wdata    <= '0;
         r_hold     <= 1'b0;
         r_tmo      <= '0;
      end else begin
         if (w_in_frame && !rx_valid) r_tmo <= r_tmo + 32'd1;
         else                         r_tmo <= '0;
         case (r_state)
            ST_IDLE: begin
               if (rx_valid) begin
                  r_byte_cnt <= '0;
                  r_is_write <= (rx_byte == CMD_W);
                  if (rx_byte == CMD_H)      r_hold <= 1'b1;
                  else if (rx_byte == CMD_G) r_hold <= 1'b0;
               end
            end
            ST_ADDR: begin
               if (rx_valid) begin
                  r_addr_sh  <= {rx_byte, r_addr_sh[23:8]};
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  if (r_byte_cnt == 2'd3) r_mem_addr <= {rx_byte, r_addr_sh} & 32'hFFFF_FFFC;
               end
            end
            ST_DATA: begin
               if (rx_valid) begin
                  r_wdata    <= {rx_byte, r_wdata[31:8]};
                  r_byte_cnt <= r_byte_cnt + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   uart_mem_bridge_tx_seq #(
      .TX_GAP(TX_GAP)
   ) u_tx_seq (
      .clk       (clk),
      .reset     (reset),
      .i_start   (w_start),
      .i_data    (w_start_data),
      .i_count   (w_start_cnt),
      .i_tx_busy (tx_busy),
      .o_busy    (w_seq_busy),
      .o_tx_valid(tx_valid),
      .o_tx_byte (tx_byte)
   );

   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_wdata;
   assign mem_wmask = (r_state == ST_WRITE) ? 4'b1111 : 4'b0000;
   assign mem_rstrb = (r_state == ST_READ);
   assign cpu_hold  = r_hold;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Scoreboard bench for uart_mem_bridge: stimulus pushes expected tx bytes and
// bus transactions, a negedge monitor pops and compares as the DUT emits them.
module tb_uart_mem_bridge;

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] data;
   } bus_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        tx_valid;
   logic [7:0]  tx_byte;
   logic        tx_busy;
   logic [31:0] mem_addr;
   logic        mem_rstrb;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_rdata;
   logic        cpu_hold;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          last_rx  = 0;
   int          busy_cnt = 0;
   logic        prev_busy = 1'b0;
   logic [31:0] rd_word  = 32'h0;

   logic [7:0]  exp_tx[$];
   bus_t        exp_bus[$];

   uart_mem_bridge #(
      .TIMEOUT_CYCLES(50),
      .TX_GAP        (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_valid (rx_valid),
      .rx_byte  (rx_byte),
      .tx_valid (tx_valid),
      .tx_byte  (tx_byte),
      .tx_busy  (tx_busy),
      .mem_addr (mem_addr),
      .mem_rstrb(mem_rstrb),
      .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask),
      .mem_rdata(mem_rdata),
      .cpu_hold (cpu_hold)
   );

   always #5 clk = ~clk;

   assign tx_busy = (busy_cnt != 0);

   // Cycle counter, UART transmitter busy model, registered memory read port
   initial begin
      mem_rdata = 32'h0BAD_0BAD;
      forever begin
         @(posedge clk);
         cyc <= cyc + 1;
         if (tx_valid)          busy_cnt <= 6;
         else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
         if (mem_rstrb) mem_rdata <= rd_word;
         else           mem_rdata <= 32'h0BAD_0BAD;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare every tx launch and bus access against the scoreboard
   initial begin
      bus_t        b;
      logic [7:0]  e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (rx_valid) last_rx = cyc;
            if (tx_valid) begin
               if (exp_tx.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_tx: got %h expected none", tx_byte);
               end else begin
                  e = exp_tx.pop_front();
                  chk("tx_byte", {24'h0, tx_byte}, {24'h0, e});
                  chk("tx_after_busy_low", {31'h0, prev_busy}, 32'h0);
               end
            end
            if (mem_wmask != 4'h0 || mem_rstrb) begin
               chk("wmask_rstrb_exclusive", {31'h0, (mem_wmask != 4'h0) && mem_rstrb}, 32'h0);
               if (exp_bus.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_bus: got addr %h wmask %h rstrb %b expected none",
                           mem_addr, mem_wmask, mem_rstrb);
               end else begin
                  b = exp_bus.pop_front();
                  chk("bus_is_write", {31'h0, mem_wmask != 4'h0}, {31'h0, b.is_wr});
                  chk("bus_addr", mem_addr, b.addr);
                  chk("bus_latency", cyc - last_rx, 32'd1);
                  if (b.is_wr) begin
                     chk("bus_wmask", {28'h0, mem_wmask}, 32'hF);
                     chk("bus_wdata", mem_wdata, b.data);
                  end
               end
            end
         end
         prev_busy = tx_busy;
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(posedge clk);
      #2;
      rx_valid = 1'b1;
      rx_byte  = b;
      @(posedge clk);
      #2;
      rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic send_w(input logic [31:0] a, input logic [31:0] d, input int gap);
      send_byte(8'h57, gap);
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], gap);
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], gap);
   endtask

   task automatic send_r(input logic [31:0] a, input int gap);
      send_byte(8'h52, gap);
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], gap);
   endtask

   task automatic wait_quiet(input string name);
      int n;
      n = 0;
      while ((exp_tx.size() != 0 || exp_bus.size() != 0) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      chk({name, "_drained"}, exp_tx.size() + exp_bus.size(), 32'd0);
      exp_tx.delete();
      exp_bus.delete();
      repeat (12) @(posedge clk);
   endtask

   task automatic chk_outputs_zero(input string name);
      @(negedge clk);
      chk({name, "_tx_valid"}, {31'h0, tx_valid}, 32'h0);
      chk({name, "_tx_byte"}, {24'h0, tx_byte}, 32'h0);
      chk({name, "_mem_addr"}, mem_addr, 32'h0);
      chk({name, "_mem_wdata"}, mem_wdata, 32'h0);
      chk({name, "_mem_ctl"}, {27'h0, mem_rstrb, mem_wmask}, 32'h0);
      chk({name, "_cpu_hold"}, {31'h0, cpu_hold}, 32'h0);
   endtask

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      repeat (3) @(posedge clk);
      chk_outputs_zero("reset");
      @(posedge clk);
      #2;
      reset = 1'b0;
      repeat (3) @(posedge clk);

      // Word write
      exp_bus.push_back('{1'b1, 32'h0000_1000, 32'hDEAD_BEEF});
      exp_tx.push_back(8'h06);
      send_w(32'h0000_1000, 32'hDEAD_BEEF, 3);
      wait_quiet("write");

      // Word read, four bytes LSB first
      rd_word = 32'hDEAD_BEEF;
      exp_bus.push_back('{1'b0, 32'h0000_1000, 32'h0});
      exp_tx.push_back(8'hEF);
      exp_tx.push_back(8'hBE);
      exp_tx.push_back(8'hAD);
      exp_tx.push_back(8'hDE);
      send_r(32'h0000_1000, 3);
      wait_quiet("read");

      // Hold / NAK while held / release
      exp_tx.push_back(8'h06);
      send_byte(8'h48, 3);
      wait_quiet("hold");
      chk("cpu_hold_after_H", {31'h0, cpu_hold}, 32'h1);
      exp_tx.push_back(8'h15);
      send_byte(8'h41, 3);
      wait_quiet("nak");
      chk("cpu_hold_after_nak", {31'h0, cpu_hold}, 32'h1);
      exp_tx.push_back(8'h06);
      send_byte(8'h47, 3);
      wait_quiet("go");
      chk("cpu_hold_after_G", {31'h0, cpu_hold}, 32'h0);

      // Truncated write frame expires: no access, no response
      send_byte(8'h57, 3);
      send_byte(8'h03, 3);
      send_byte(8'h20, 3);
      send_byte(8'h00, 3);
      send_byte(8'h00, 3);
      repeat (80) @(posedge clk);
      rd_word = 32'h1234_5678;
      exp_bus.push_back('{1'b0, 32'h0000_0400, 32'h0});
      exp_tx.push_back(8'h78);
      exp_tx.push_back(8'h56);
      exp_tx.push_back(8'h34);
      exp_tx.push_back(8'h12);
      send_r(32'h0000_0400, 3);
      wait_quiet("after_timeout");

      // Unaligned write address, slow bytes still inside the timeout window
      exp_bus.push_back('{1'b1, 32'h0000_1000, 32'h4433_2211});
      exp_tx.push_back(8'h06);
      send_w(32'h0000_1003, 32'h4433_2211, 40);
      wait_quiet("unaligned");

      // Bytes arriving while the read response is being sent are dropped
      exp_tx.push_back(8'h06);
      send_byte(8'h48, 3);
      wait_quiet("hold2");
      rd_word = 32'hCAFE_F00D;
      exp_bus.push_back('{1'b0, 32'h0000_1000, 32'h0});
      exp_tx.push_back(8'h0D);
      exp_tx.push_back(8'hF0);
      exp_tx.push_back(8'hFE);
      exp_tx.push_back(8'hCA);
      send_r(32'h0000_1000, 2);
      repeat (6) @(posedge clk);
      send_byte(8'h47, 2);
      send_byte(8'h41, 2);
      send_byte(8'h57, 2);
      wait_quiet("drop_in_send");
      chk("cpu_hold_after_dropped_G", {31'h0, cpu_hold}, 32'h1);

      // Reset in the middle of the data phase
      send_byte(8'h57, 3);
      send_byte(8'h00, 3);
      send_byte(8'h10, 3);
      send_byte(8'h00, 3);
      send_byte(8'h00, 3);
      send_byte(8'hAA, 3);
      send_byte(8'hBB, 0);
      #2;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      chk_outputs_zero("midreset");
      @(posedge clk);
      #2;
      reset = 1'b0;
      repeat (20) @(posedge clk);
      exp_bus.push_back('{1'b1, 32'h0000_1008, 32'h0403_0201});
      exp_tx.push_back(8'h06);
      send_w(32'h0000_1008, 32'h0403_0201, 3);
      wait_quiet("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
